// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with a small receive FIFO
//
// Purpose:
//   Deserialises the host-to-board serial line into bytes for the core.
//   The raw line is synchronised, a 1->0 edge starts a frame, the start bit
//   is re-checked at mid-bit, data bits are sampled LSB first at bit
//   centres, and the stop bit decides whether the byte is pushed into the
//   FIFO or flagged. The consumer pops with a valid/ready handshake.
//
// Ports:
//   clk      - system clock, single domain
//   rstn     - synchronous active-low reset
//   rxd      - raw serial input, asynchronous, idles high
//   rdata    - byte at the FIFO head, 0 while rvalid=0
//   rvalid   - FIFO holds at least one byte
//   rready   - consumer takes rdata at a clk edge when rvalid&&rready
//   count    - FIFO occupancy, 0..FIFO_DEPTH
//   ferr     - sticky framing error (stop bit sampled low)
//   overrun  - sticky overrun (good byte arrived while FIFO full)
//   err_clr  - one-cycle pulse clearing ferr and overrun
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rxd,
  output logic [7:0]       rdata,
  output logic             rvalid,
  input  logic             rready,
  output logic [CNT_W-1:0] count,
  output logic             ferr,
  output logic             overrun,
  input  logic             err_clr
);

  localparam int H  = CLK_PER_BIT / 2;
  localparam int BW = $clog2(CLK_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0]    HALF_LAST = BW'(H - 1);
  localparam logic [BW-1:0]    BAUD_ONE  = BW'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  // synchroniser and edge history
  logic sync1_q, sync1_d;
  logic rxd_s_q, rxd_s_d;
  logic rxd_d_q, rxd_d_d;

  // receive FSM
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q,  baud_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // flags
  logic ferr_q, ferr_d;
  logic ovr_q,  ovr_d;

  // per-cycle events
  logic stop_ok;
  logic stop_bad;
  logic full;
  logic pop;
  logic push;
  logic ovr_ev;

  always_comb begin
    sync1_d = rxd;
    rxd_s_d = sync1_q;
    rxd_d_d = rxd_s_q;

    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        // The detection cycle itself is baud tick 0, so the start-bit
        // check lands H-1 cycles after it and the stop-bit sample lands
        // H-1 + 9*CLK_PER_BIT cycles after it.
        if (rxd_d_q && !rxd_s_q) begin
          state_d = S_START;
          baud_d  = BAUD_ONE;
        end
      end
      S_START: begin
        if (baud_q == HALF_LAST) begin
          if (rxd_s_q) begin
            // line went back high before mid-bit: glitch, not a start bit
            state_d = S_IDLE;
            baud_d  = '0;
          end else begin
            state_d = S_DATA;
            baud_d  = '0;
            bit_d   = 3'd0;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          baud_d  = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          // back to IDLE in the sampling cycle so a start edge right after
          // the stop bit is caught without an idle gap
          state_d = S_IDLE;
          baud_d  = '0;
          if (rxd_s_q) begin
            stop_ok = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  always_comb begin
    full   = (count_q == CNT_FULL);
    pop    = (count_q != '0) && rready;
    // a pop in the same cycle frees the slot the new byte needs
    push   = stop_ok && (!full || pop);
    ovr_ev = stop_ok && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // a new error event takes priority over a coincident clear
    ferr_d = ferr_q;
    if (err_clr) begin
      ferr_d = 1'b0;
    end
    if (stop_bad) begin
      ferr_d = 1'b1;
    end

    ovr_d = ovr_q;
    if (err_clr) begin
      ovr_d = 1'b0;
    end
    if (ovr_ev) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      rxd_d_q  <= 1'b1;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      rxd_s_q  <= rxd_s_d;
      rxd_d_q  <= rxd_d_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // storage needs no reset: entries are only visible through rvalid
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rvalid  = (count_q != '0);
  assign rdata   = rvalid ? mem_q[rd_ptr_q] : 8'h00;
  assign count   = count_q;
  assign ferr    = ferr_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int H     = CPB / 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rxd = 1'b1;
  logic          rready = 1'b0;
  logic          err_clr = 1'b0;
  logic [7:0]    rdata;
  logic          rvalid;
  logic [CW-1:0] count;
  logic          ferr;
  logic          overrun;

  int checks = 0;
  int failures = 0;
  int rv_cycles = 0;
  bit rand_done = 1'b0;

  // reference model: bytes the receiver should deliver, in order, and flags
  logic [7:0] exp_q[$];
  bit exp_ferr = 1'b0;
  bit exp_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_PER_BIT(CPB),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rxd    (rxd),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rready (rready),
    .count  (count),
    .ferr   (ferr),
    .overrun(overrun),
    .err_clr(err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a clk edge; drives one 8N1 frame. The stop bit is
  // sampled at the edge H+2+9*CPB after the call (2 synchroniser stages,
  // then H-1+9*CPB after edge detection), which is where the model decides.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit model_en);
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = stop;
    wait_cyc(H + 2);
    if (model_en) begin
      if (!stop) begin
        exp_ferr = 1'b1;
      end else if (exp_q.size() < DEPTH) begin
        exp_q.push_back(b);
      end else begin
        exp_ovr = 1'b1;
      end
    end
    wait_cyc(CPB - H - 2);
    rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // monitor: every accepted byte is compared with the model's head
  always @(negedge clk) begin
    if (rstn) begin
      if (rvalid) begin
        rv_cycles++;
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          chk("pop_with_model_empty", {31'd0, rvalid}, 32'd0);
        end else begin
          chk("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stop;

    wait_cyc(3);
    rstn = 1'b1;
    chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_rdata", {24'd0, rdata}, 32'd0);

    // 1: single byte, consumer always ready
    rready = 1'b1;
    rv_cycles = 0;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_cyc(10);
    chk("t1_rvalid_cycles", rv_cycles, 32'd1);
    chk("t1_drained", exp_q.size(), 32'd0);
    chk("t1_count", {29'd0, count}, 32'd0);
    chk("t1_ferr", {31'd0, ferr}, {31'd0, exp_ferr});
    chk("t1_overrun", {31'd0, overrun}, {31'd0, exp_ovr});

    // 2: 5-cycle glitch is a false start, next frame still works
    rxd = 1'b0;
    wait_cyc(5);
    rxd = 1'b1;
    wait_cyc(3 * CPB);
    chk("t2_count", {29'd0, count}, 32'd0);
    chk("t2_rvalid", {31'd0, rvalid}, 32'd0);
    chk("t2_ferr", {31'd0, ferr}, 32'd0);
    chk("t2_overrun", {31'd0, overrun}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_cyc(10);
    chk("t2_drained", exp_q.size(), 32'd0);

    // 3: framing error and clear
    send_frame(8'h55, 1'b0, 1'b1);
    wait_cyc(CPB);
    chk("t3_ferr", {31'd0, ferr}, {31'd0, exp_ferr});
    chk("t3_count", {29'd0, count}, 32'd0);
    pulse_clr();
    chk("t3_ferr_cleared", {31'd0, ferr}, 32'd0);

    // 4: fill with no consumer, fifth byte overruns
    rready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
    end
    wait_cyc(4);
    chk("t4_count", {29'd0, count}, 32'd4);
    chk("t4_count_model", {29'd0, count}, exp_q.size());
    chk("t4_overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    chk("t4_head", {24'd0, rdata}, 32'h01);
    rready = 1'b1;
    wait_cyc(6);
    rready = 1'b0;
    chk("t4_rvalid_empty", {31'd0, rvalid}, 32'd0);
    chk("t4_drained", exp_q.size(), 32'd0);

    // 5: full FIFO, pop exactly on the stop-sample cycle of the fifth byte
    pulse_clr();
    chk("t5_overrun_cleared", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b1);
    end
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      begin
        wait_cyc(H + 1 + 9 * CPB);
        rready = 1'b1;
        wait_cyc(1);
        rready = 1'b0;
      end
    join
    wait_cyc(2);
    chk("t5_count", {29'd0, count}, 32'd4);
    chk("t5_overrun", {31'd0, overrun}, 32'd0);
    chk("t5_tail_model", {24'd0, exp_q[exp_q.size()-1]}, 32'h77);
    rready = 1'b1;
    wait_cyc(6);
    rready = 1'b0;
    chk("t5_drained", exp_q.size(), 32'd0);

    // random traffic: random bytes, occasional bad stop, random consumer
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          b = 8'($urandom);
          stop = ($urandom_range(0, 7) != 0);
          send_frame(b, stop, 1'b1);
          if (!stop) begin
            wait_cyc(2);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rready = ($urandom_range(0, 9) < 3);
          wait_cyc(1);
        end
      end
    join
    rready = 1'b1;
    wait_cyc(8);
    rready = 1'b0;
    chk("rand_ferr", {31'd0, ferr}, {31'd0, exp_ferr});
    chk("rand_overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_count", {29'd0, count}, 32'd0);

    // 6: reset in the middle of frame 0xF0 (during bit 4, line high)
    send_frame(8'h12, 1'b0, 1'b1);
    wait_cyc(4);
    send_frame(8'h99, 1'b1, 1'b1);
    wait_cyc(4);
    chk("t6_pre_count", {29'd0, count}, exp_q.size());
    chk("t6_pre_ferr", {31'd0, ferr}, {31'd0, exp_ferr});
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        wait_cyc(5 * CPB + 4);
        rstn = 1'b0;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
        wait_cyc(1);
        rstn = 1'b1;
        chk("t6_rvalid", {31'd0, rvalid}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_ferr", {31'd0, ferr}, 32'd0);
        chk("t6_overrun", {31'd0, overrun}, 32'd0);
        chk("t6_rdata", {24'd0, rdata}, 32'd0);
      end
    join
    wait_cyc(4);
    chk("t6_no_partial", {29'd0, count}, 32'd0);
    rready = 1'b1;
    rv_cycles = 0;
    send_frame(8'h0F, 1'b1, 1'b1);
    wait_cyc(10);
    chk("t6_rx_cycles", rv_cycles, 32'd1);
    chk("t6_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver (8N1) that deserialises the host-to-board line into bytes for the core.
- Counterpart of the core's transmit path on the same link.
- Synchronises the raw rxd pin, detects and validates the start bit, samples at mid-bit, checks the stop bit, and buffers bytes in a small FIFO.
- Consumer side is a valid/ready handshake; error flags are sticky.

Parameters:
CLK_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy output.

Ports:
clk  input  1  system clock; single clock domain.
rstn  input  1  synchronous, active-low reset.
rxd  input  1  raw serial line, asynchronous to clk, idle high.
rdata  output  8  byte at FIFO head; valid only while rvalid=1.
rvalid  output  1  FIFO not empty.
rready  input  1  consumer accepts rdata when rvalid&&rready at a clk edge.
count  output  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.
ferr  output  1  sticky framing error (stop bit sampled 0).
overrun  output  1  sticky overrun (valid byte received while FIFO full).
err_clr  input  1  one-cycle pulse that clears ferr and overrun.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - synchroniser flops set to 1.
  - FSM goes to IDLE; bit counter, baud counter and FIFO pointers go to 0.
  - Outputs: rvalid=0, count=0, ferr=0, overrun=0, rdata=0.
  - Reset asserted mid-frame abandons the frame. No partial byte is ever pushed.
- Synchronisation:
  - rxd passes through 2 flops to give rxd_s, plus one history flop rxd_d.
  - All timing below is relative to rxd_s.
- Let H = CLK_PER_BIT/2 (integer division).
- IDLE:
  - Move to START when rxd_d=1 and rxd_s=0 (falling edge); baud counter cleared.
  - A line held low (break) does not retrigger; a new 1->0 edge is required.
- START:
  - At baud count H-1, sample rxd_s.
  - If 1, false start: return to IDLE with no flag.
  - If 0, go to DATA; baud counter cleared, bit index 0.
- DATA:
  - Sample rxd_s every CLK_PER_BIT cycles (count CLK_PER_BIT-1), i.e. at bit centres.
  - Bits arrive LSB first into the shift register.
  - After the 8th sample, go to STOP.
- STOP:
  - At the next CLK_PER_BIT-1 count, sample rxd_s, then return to IDLE in the same cycle.
  - Stop sample = 1 and FIFO not full, or full with a pop in that same cycle: push the byte.
  - Stop sample = 1 and FIFO full with no pop: byte dropped, overrun<=1.
  - Stop sample = 0: byte discarded, ferr<=1, no push.
- Sample timing: the stop-bit sample falls H-1 + 9*CLK_PER_BIT cycles after the falling-edge detection cycle.
- FIFO:
  - Pushed byte is visible the following cycle: rvalid=1, rdata=byte when previously empty.
  - Pop when rvalid&&rready. Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. rdata is the head entry, read combinationally from the storage array.
- Flags:
  - Sticky until err_clr=1.
  - If err_clr coincides with a new error event, the new event wins (flag stays 1).
  - Errors do not stall reception.
- Back-to-back frames: the next start edge is detected as soon as rxd_s falls after the stop bit, with no idle gap required.

Test Plan (CLK_PER_BIT=16, FIFO_DEPTH=4):
1. Reset, then send 0xA5 at 16 clk/bit with rready=1:
   - rvalid pulses high for exactly one cycle with rdata=0xA5.
   - count returns to 0; ferr=0, overrun=0.
2. rxd glitch low for 5 cycles (less than H) from idle:
   - no push, no flags, FSM back in IDLE.
   - A following valid 0x3C frame is received correctly.
3. Send 0x55 with stop bit driven 0:
   - ferr=1, count=0.
   - err_clr pulse clears ferr to 0 the next cycle.
4. rready=0, send 0x01..0x05 back-to-back:
   - count=4, overrun=1, head rdata=0x01.
   - Popping 4 times yields 0x01, 0x02, 0x03, 0x04 in order, then rvalid=0.
5. FIFO full with rready=1 asserted on the exact stop-sample cycle of a 5th byte 0x77:
   - pop and push coexist, count stays 4, overrun stays 0.
   - 0x77 is the last byte drained.
6. Assert rstn=0 for one cycle during bit 4 of frame 0xF0:
   - all outputs at reset values, no byte pushed.
   - The next full frame 0x0F is received correctly.
